// File: rtl/bscan_user_dr_ctrl.sv
// User JTAG data register behind BSCAN user-chain ports, fully oversampled in the CLK domain.
// Captures CAP_DATA, shifts LSB-first, and hands the updated word off via valid/ready.
module bscan_user_dr_ctrl #(
  parameter int DR_WIDTH    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int JTAG_CHAIN  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BS_DRCK,
  input  logic                BS_SEL,
  input  logic                BS_CAPTURE,
  input  logic                BS_SHIFT,
  input  logic                BS_UPDATE,
  input  logic                BS_RESET,
  input  logic                BS_TDI,
  output logic                BS_TDO,
  input  logic [DR_WIDTH-1:0] CAP_DATA,
  output logic [DR_WIDTH-1:0] UPD_DATA,
  output logic                UPD_VALID,
  input  logic                UPD_READY,
  output logic                LEN_ERR,
  output logic                OVERFLOW,
  input  logic                ERR_CLR,
  output logic [1:0]          CHAIN_ID
);
  localparam int CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DR_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CAPT, SHFT} state_t;

  state_t                          state, state_n;
  logic [SYNC_STAGES-1:0][6:0]     sync_q;
  logic [6:0]                      bs_in, bs_s;
  logic                            drck_s, sel_s, cap_s, shf_s, upd_s, rst_s, tdi_s;
  logic                            drck_prev, upd_prev, e, u, cnt_full;
  logic [DR_WIDTH-1:0]             sr;
  logic [CW-1:0]                   cnt;

  assign CHAIN_ID = 2'(JTAG_CHAIN - 1);

  // All BSCAN strobes and TDI share one synchroniser so they stay cycle-aligned.
  assign bs_in = {BS_TDI, BS_RESET, BS_UPDATE, BS_SHIFT, BS_CAPTURE, BS_SEL, BS_DRCK};
  assign bs_s  = sync_q[SYNC_STAGES-1];
  assign {tdi_s, rst_s, upd_s, shf_s, cap_s, sel_s, drck_s} = bs_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= '0;
      drck_prev <= 1'b0;
      upd_prev  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bs_in};
      drck_prev <= drck_s;
      upd_prev  <= upd_s;
    end
  end

  assign e        = drck_s & ~drck_prev & sel_s;
  assign u        = upd_s & ~upd_prev & sel_s;
  assign cnt_full = (cnt == CNT_FULL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (rst_s)                                 state_n = IDLE;
    else if (state == IDLE && e && cap_s)      state_n = CAPT;
    else if (state != IDLE && e && shf_s && !cap_s) state_n = SHFT;
    else if (state == SHFT && u)               state_n = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr        <= '0;
      cnt       <= '0;
      BS_TDO    <= 1'b0;
      UPD_DATA  <= '0;
      UPD_VALID <= 1'b0;
      LEN_ERR   <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      BS_TDO <= sr[0];
      if (rst_s) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        if (e && cap_s) begin
          sr  <= CAP_DATA;
          cnt <= '0;
        end else if (e && shf_s) begin
          sr <= {tdi_s, sr[DR_WIDTH-1:1]};
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end
        if (u) cnt <= '0;
      end
      // A consumer pop in the same cycle as u frees the slot for the new word.
      if (u && cnt_full && (!UPD_VALID || UPD_READY)) begin
        UPD_DATA  <= sr;
        UPD_VALID <= 1'b1;
      end else if (UPD_VALID && UPD_READY) begin
        UPD_VALID <= 1'b0;
      end
      if (ERR_CLR) begin
        LEN_ERR  <= 1'b0;
        OVERFLOW <= 1'b0;
      end
      if (u && !cnt_full)                          LEN_ERR  <= 1'b1;
      if (u && cnt_full && UPD_VALID && !UPD_READY) OVERFLOW <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bscan_user_dr_ctrl.sv
// Directed bench: update words go through a scoreboard queue checked by a monitor on handshake;
// TDO bits and flags are compared against hand-computed values.
module tb_bscan_user_dr_ctrl;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        BS_DRCK = 0, BS_SEL = 0, BS_CAPTURE = 0, BS_SHIFT = 0, BS_UPDATE = 0, BS_RESET = 0, BS_TDI = 0;
  logic        BS_TDO;
  logic [31:0] CAP_DATA = '0, UPD_DATA;
  logic        UPD_VALID, UPD_READY = 0, LEN_ERR, OVERFLOW, ERR_CLR = 0;
  logic [1:0]  CHAIN_ID;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  bscan_user_dr_ctrl #(.DR_WIDTH(32), .SYNC_STAGES(2), .JTAG_CHAIN(1)) dut (
    .CLK(CLK), .RST(RST), .BS_DRCK(BS_DRCK), .BS_SEL(BS_SEL), .BS_CAPTURE(BS_CAPTURE),
    .BS_SHIFT(BS_SHIFT), .BS_UPDATE(BS_UPDATE), .BS_RESET(BS_RESET), .BS_TDI(BS_TDI),
    .BS_TDO(BS_TDO), .CAP_DATA(CAP_DATA), .UPD_DATA(UPD_DATA), .UPD_VALID(UPD_VALID),
    .UPD_READY(UPD_READY), .LEN_ERR(LEN_ERR), .OVERFLOW(OVERFLOW), .ERR_CLR(ERR_CLR),
    .CHAIN_ID(CHAIN_ID));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted update word must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && UPD_VALID && UPD_READY) begin
      if (exp_q.size() == 0) chk("upd_unexpected", UPD_DATA, 32'hxxxx_xxxx);
      else chk("upd_data", UPD_DATA, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drck_pulse();
    BS_DRCK = 1; tick(8);
    BS_DRCK = 0; tick(8);
  endtask

  task automatic capture(input logic [31:0] d);
    CAP_DATA = d; BS_CAPTURE = 1;
    drck_pulse();
    BS_CAPTURE = 0;
  endtask

  task automatic shift_bits(input logic [31:0] d, input int from, input int to,
                            input bit do_chk, input logic [31:0] exp_tdo);
    BS_SHIFT = 1;
    for (int i = from; i < to; i++) begin
      BS_TDI = d[i];
      if (do_chk) chk($sformatf("tdo[%0d]", i), 32'(BS_TDO), 32'(exp_tdo[i]));
      drck_pulse();
    end
    BS_SHIFT = 0;
    tick(2);
  endtask

  // ready_pulse raises READY only on the cycle the synchronised UPDATE edge is acted on.
  task automatic do_update(input bit ready_pulse);
    BS_UPDATE = 1;
    if (ready_pulse) begin
      tick(2); UPD_READY = 1; tick(1); UPD_READY = 0; tick(5);
    end else tick(8);
    BS_UPDATE = 0;
    tick(8);
  endtask

  initial begin
    tick(3);
    chk("rst_tdo", 32'(BS_TDO), 0);
    chk("rst_valid", 32'(UPD_VALID), 0);
    chk("rst_data", UPD_DATA, 0);
    chk("rst_lenerr", 32'(LEN_ERR), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("chain_id", 32'(CHAIN_ID), 0);
    RST = 0; BS_SEL = 1; tick(2);

    // Capture + shift + accepted update
    capture(32'hA5A5_0F0F);
    shift_bits(32'hDEAD_BEEF, 0, 32, 1, 32'hA5A5_0F0F);
    exp_q.push_back(32'hDEAD_BEEF);
    UPD_READY = 1; do_update(0); UPD_READY = 0;
    chk("upd_valid_clr", 32'(UPD_VALID), 0);
    chk("upd_data_hold", UPD_DATA, 32'hDEAD_BEEF);
    chk("no_lenerr", 32'(LEN_ERR), 0);

    // Short shift -> length error, then clear
    capture(32'h0);
    shift_bits(32'h1357_9BDF, 0, 31, 0, 0);
    do_update(0);
    chk("len_err", 32'(LEN_ERR), 1);
    chk("len_no_valid", 32'(UPD_VALID), 0);
    ERR_CLR = 1; tick(1); ERR_CLR = 0; tick(1);
    chk("len_err_clr", 32'(LEN_ERR), 0);

    // Overflow: second update while first still pending
    capture(32'h0); shift_bits(32'h1234_5678, 0, 32, 0, 0); do_update(0);
    chk("ovf_valid1", 32'(UPD_VALID), 1);
    capture(32'h0); shift_bits(32'h0BAD_F00D, 0, 32, 0, 0); do_update(0);
    chk("ovf_flag", 32'(OVERFLOW), 1);
    chk("ovf_data", UPD_DATA, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    UPD_READY = 1; tick(2); UPD_READY = 0; tick(1);
    chk("ovf_drained", 32'(UPD_VALID), 0);

    // Reset mid-shift with a pending word and a sticky flag
    capture(32'h0); shift_bits(32'hCAFE_0001, 0, 32, 0, 0); do_update(0);
    capture(32'hFFFF_FFFF); shift_bits(32'h0, 0, 10, 0, 0);
    RST = 1; tick(1);
    chk("mid_rst_tdo", 32'(BS_TDO), 0);
    chk("mid_rst_valid", 32'(UPD_VALID), 0);
    chk("mid_rst_data", UPD_DATA, 0);
    chk("mid_rst_ovf", 32'(OVERFLOW), 0);
    RST = 0; tick(2);
    capture(32'hA5A5_0F0F);
    shift_bits(32'h3C3C_1234, 0, 32, 1, 32'hA5A5_0F0F);
    exp_q.push_back(32'h3C3C_1234);
    UPD_READY = 1; do_update(0); UPD_READY = 0;

    // Consumer pops on the same cycle as the second update: no overflow
    capture(32'h0); shift_bits(32'h1111_2222, 0, 32, 0, 0); do_update(0);
    capture(32'h0); shift_bits(32'h3333_4444, 0, 32, 0, 0);
    exp_q.push_back(32'h1111_2222);
    do_update(1);
    exp_q.push_back(32'h3333_4444);
    chk("var_no_ovf", 32'(OVERFLOW), 0);
    chk("var_data", UPD_DATA, 32'h3333_4444);
    chk("var_valid", 32'(UPD_VALID), 1);
    UPD_READY = 1; tick(2); UPD_READY = 0; tick(1);

    // SEL gating: edges with SEL=0 must be ignored
    capture(32'h0000_0420);
    shift_bits(32'h5A5A_C3C3, 0, 5, 1, 32'h0000_0420);
    BS_SEL = 0; BS_SHIFT = 1; tick(2);
    repeat (3) drck_pulse();
    BS_UPDATE = 1; tick(8); BS_UPDATE = 0; tick(8);
    BS_SHIFT = 0; tick(4); BS_SEL = 1; tick(4);
    chk("gate_tdo", 32'(BS_TDO), 1);
    chk("gate_valid", 32'(UPD_VALID), 0);
    chk("gate_lenerr", 32'(LEN_ERR), 0);
    shift_bits(32'h5A5A_C3C3, 5, 32, 1, 32'h0000_0420);
    exp_q.push_back(32'h5A5A_C3C3);
    UPD_READY = 1; do_update(0); UPD_READY = 0;
    chk("gate_lenerr2", 32'(LEN_ERR), 0);

    // TAP reset mid-shift clears sr and cnt
    capture(32'h0000_0420);
    shift_bits(32'h0, 0, 10, 0, 0);
    BS_RESET = 1; tick(6); BS_RESET = 0; tick(6);
    chk("tap_rst_tdo", 32'(BS_TDO), 0);
    shift_bits(32'h600D_CAFE, 0, 32, 0, 0);
    exp_q.push_back(32'h600D_CAFE);
    UPD_READY = 1; do_update(0); UPD_READY = 0;
    chk("tap_rst_lenerr", 32'(LEN_ERR), 0);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin tick(1); n++; end
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
